imem_loader: RTL

Boot-time writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, parses a 2-byte word-count header, packs little-endian bytes into DATA-wide words and issues single-cycle write strobes at consecutive word addresses. Holds the core in stall while loading and releases it only after a clean load. Sits between the boot byte source (UART RX or debug port) and the instruction memory write port; top level muxes WA onto the memory address while core_hold is high.

---
 rtl/imem_loader_pkg.sv | 40 ++++
 rtl/imem_loader_byte_packer.sv | 49 ++++
 rtl/imem_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants, loader state type and a state decode helper.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the trailing checksum state).
package imem_loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR0    = 3'd1;
    localparam logic [2:0] ST_HDR1    = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CHK     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        HDR0    = ST_HDR0,
        HDR1    = ST_HDR1,
        PAYLOAD = ST_PAYLOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK     = ST_CHK,
`endif
        DONE    = ST_DONE
    } state_t;

    // States in which the loader takes bytes from the stream.
    function automatic logic accepts_bytes(input state_t s);
        logic r;
        r = 1'b0;
        case (s)
            HDR0, HDR1, PAYLOAD: r = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:                 r = 1'b1;
`endif
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: shifts 8-bit lanes into a little-endian 32-bit word,
// tracks the byte index and emits a registered one-cycle word-complete pulse.
// Optional feature macro: none (IMEM_LOADER_CHECKSUM_EN does not affect this block).
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        completing,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam int LANE_BITS = 8 * (BYTES_PER_WORD - 1);

    logic [1:0]           idx_q;
    logic [LANE_BITS-1:0] acc_q;

    // The byte being accepted this cycle is the last lane of a word.
    assign completing = in_valid && (idx_q == 2'(BYTES_PER_WORD - 1));

    // Shift bytes in from the top so the first byte lands in bits [7:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            acc_q      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            word_valid <= completing;
            if (clear) begin
                idx_q <= '0;
            end else if (in_valid) begin
                if (completing) begin
                    idx_q <= '0;
                    word  <= {in_byte, acc_q};
                end else begin
                    idx_q <= idx_q + 2'd1;
                    acc_q <= {in_byte, acc_q[LANE_BITS-1:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer. Parses a 2-byte word count,
// packs payload bytes into words, writes them at consecutive addresses and holds
// the core in stall until a clean load completes.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int              DATA      = 32,
    parameter int              ADDR      = 32,
    parameter int              MEM_DEPTH = 256,
    parameter logic [ADDR-1:0] BASE_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic            rx_ready,
    output logic            WE,
    output logic [DATA-1:0] WD,
    output logic [ADDR-1:0] WA,
    output logic            core_hold,
    output logic            done,
    output logic            err
);

    localparam int          CNT_W   = 8 * HDR_BYTES;
    localparam logic [31:0] DEPTH_U = MEM_DEPTH;

    state_t           state_q, state_d;
    logic             err_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] hdr_count;
    logic [CNT_W-1:0] word_idx_q;
    logic             xfer;
    logic             restart;
    logic             pk_in;
    logic             pk_completing;
    logic             pk_valid;
    logic [31:0]      pk_word;
    logic             last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    assign xfer      = rx_valid && rx_ready;
    assign restart   = start && (state_q == IDLE || state_q == DONE);
    assign pk_in     = xfer && (state_q == PAYLOAD);
    assign hdr_count = {rx_data, count_q[7:0]};
    assign last_word = pk_completing && (word_idx_q == count_q - CNT_W'(1));

    imem_loader_byte_packer u_byte_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (restart),
        .in_valid   (pk_in),
        .in_byte    (rx_data),
        .completing (pk_completing),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    assign WE = pk_valid;
    assign WD = pk_word;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and next-error logic.
    always_comb begin
        // NOTE: defaults first so every path assigns state_d/err_d and no latch is inferred.
        state_d = state_q;
        err_d   = err;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HDR0;
                    err_d   = 1'b0;
                end
            end
            HDR0: begin
                if (xfer) state_d = HDR1;
            end
            HDR1: begin
                if (xfer) begin
                    if (hdr_count == '0) begin
                        state_d = DONE;
                    end else if (32'(hdr_count) > DEPTH_U) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    state_d = DONE;
                    if (rx_data != csum_q) err_d = 1'b1;
                end
            end
`endif
            DONE: begin
                if (start) begin
                    state_d = HDR0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            core_hold <= 1'b1;
        end else begin
            rx_ready  <= accepts_bytes(state_d);
            done      <= (state_d == DONE);
            err       <= err_d;
            core_hold <= !((state_d == DONE) && !err_d);
        end
    end

    // Header count capture, word index and write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            word_idx_q <= '0;
            WA         <= BASE_ADDR;
        end else begin
            if (xfer && state_q == HDR0) count_q[7:0]  <= rx_data;
            if (xfer && state_q == HDR1) count_q[15:8] <= rx_data;
            if (restart) begin
                word_idx_q <= '0;
            end else if (pk_completing) begin
                word_idx_q <= word_idx_q + CNT_W'(1);
                WA         <= BASE_ADDR + (ADDR'(word_idx_q) << 2);
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over header and payload bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (restart) begin
            csum_q <= '0;
        end else if (xfer && (state_q == HDR0 || state_q == HDR1 || state_q == PAYLOAD)) begin
            csum_q <= csum_q ^ rx_data;
        end
    end
`endif

endmodule
